// File: rtl/axi_clip_detect.sv
// Receive-side clip detector: sign-extends a narrow AXI-stream sample stream
// and reports, per packet, how many samples sat exactly at a saturation code.
module axi_clip_detect #(
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_OUT = 24,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH_IN-1:0]  i_tdata,
    input  logic                 i_tlast,
    input  logic                 i_tvalid,
    output logic                 i_tready,
    output logic [WIDTH_OUT-1:0] o_tdata,
    output logic                 o_tlast,
    output logic                 o_tvalid,
    input  logic                 o_tready,
    output logic [CNT_WIDTH-1:0] s_tdata,
    output logic                 s_tvalid,
    input  logic                 s_tready,
    output logic                 clip_sticky,
    input  logic                 clear_sticky
);

    localparam logic [WIDTH_IN-1:0]  POS_MAX = {1'b0, {(WIDTH_IN-1){1'b1}}};
    localparam logic [WIDTH_IN-1:0]  NEG_MIN = {1'b1, {(WIDTH_IN-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    if (WIDTH_OUT < WIDTH_IN) begin : g_width_check
        $error("axi_clip_detect: WIDTH_OUT must be >= WIDTH_IN");
    end

    logic [WIDTH_OUT-1:0] ext_data;

    // A zero-width replication is illegal, so equal widths take a plain copy.
    if (WIDTH_OUT == WIDTH_IN) begin : g_no_ext
        assign ext_data = i_tdata;
    end else begin : g_ext
        assign ext_data = {{(WIDTH_OUT-WIDTH_IN){i_tdata[WIDTH_IN-1]}}, i_tdata};
    end

    logic                 o_tvalid_q, o_tvalid_d;
    logic [WIDTH_OUT-1:0] o_tdata_q,  o_tdata_d;
    logic                 o_tlast_q,  o_tlast_d;
    logic                 s_tvalid_q, s_tvalid_d;
    logic [CNT_WIDTH-1:0] s_tdata_q,  s_tdata_d;
    logic [CNT_WIDTH-1:0] cnt_q,      cnt_d;
    logic                 sticky_q,   sticky_d;

    logic                 clip;
    logic                 ready;
    logic                 accept;
    logic [CNT_WIDTH-1:0] cnt_inc;

    always_comb begin
        clip    = (i_tdata == POS_MAX) | (i_tdata == NEG_MIN);
        // A last beat may only enter when the status slot can take its count.
        ready   = (~o_tvalid_q | o_tready) & (~i_tlast | ~s_tvalid_q | s_tready);
        accept  = i_tvalid & ready;
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + (clip ? CNT_ONE : '0));
    end

    always_comb begin
        o_tvalid_d = o_tvalid_q;
        o_tdata_d  = o_tdata_q;
        o_tlast_d  = o_tlast_q;
        s_tvalid_d = s_tvalid_q;
        s_tdata_d  = s_tdata_q;
        cnt_d      = cnt_q;
        sticky_d   = sticky_q;

        if (o_tvalid_q & o_tready) begin
            o_tvalid_d = 1'b0;
        end
        if (s_tvalid_q & s_tready) begin
            s_tvalid_d = 1'b0;
        end

        if (accept) begin
            o_tvalid_d = 1'b1;
            o_tdata_d  = ext_data;
            o_tlast_d  = i_tlast;
            if (i_tlast) begin
                s_tvalid_d = 1'b1;
                s_tdata_d  = cnt_inc;
                cnt_d      = '0;
            end else begin
                cnt_d      = cnt_inc;
            end
        end

        if (accept & clip) begin
            sticky_d = 1'b1;
        end else if (clear_sticky) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_tvalid_q <= 1'b0;
            o_tdata_q  <= '0;
            o_tlast_q  <= 1'b0;
            s_tvalid_q <= 1'b0;
            s_tdata_q  <= '0;
            cnt_q      <= '0;
            sticky_q   <= 1'b0;
        end else begin
            o_tvalid_q <= o_tvalid_d;
            o_tdata_q  <= o_tdata_d;
            o_tlast_q  <= o_tlast_d;
            s_tvalid_q <= s_tvalid_d;
            s_tdata_q  <= s_tdata_d;
            cnt_q      <= cnt_d;
            sticky_q   <= sticky_d;
        end
    end

    assign i_tready    = ready;
    assign o_tvalid    = o_tvalid_q;
    assign o_tdata     = o_tdata_q;
    assign o_tlast     = o_tlast_q;
    assign s_tvalid    = s_tvalid_q;
    assign s_tdata     = s_tdata_q;
    assign clip_sticky = sticky_q;

endmodule
